// File: rtl/cake_place_ctrl.sv
// cake_place_ctrl: places the cake for the snake game.
// Pulses the generator load strobe, grid-aligns and bounds-checks the
// captured candidate, asks the occupancy unit whether the snake body
// covers it, retries on a bad candidate and falls back to a fixed cell
// after MAX_TRIES rejections.
// Optional build macro CAKE_TIMEOUT_EN: relocate the cake after it has
// sat uneaten for TIMEOUT_CYC cycles.
module cake_place_ctrl #(
  parameter int GRID_LOG2   = 4,
  parameter int X_MIN       = 16,
  parameter int X_MAX       = 608,
  parameter int Y_MIN       = 16,
  parameter int Y_MAX       = 448,
  parameter int MAX_TRIES   = 8,
  parameter int DEF_X       = 304,
  parameter int DEF_Y       = 304,
  parameter int TIMEOUT_CYC = 500000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       game_start,
  input  logic       eaten,
  output logic       rand_drive,
  input  logic [9:0] rand_x,
  input  logic [9:0] rand_y,
  output logic       chk_req,
  output logic [9:0] chk_x,
  output logic [9:0] chk_y,
  input  logic       chk_ack,
  input  logic       chk_hit,
  output logic [9:0] cake_x,
  output logic [9:0] cake_y,
  output logic       cake_valid,
  output logic       fallback,
  output logic [7:0] eat_cnt
);

  localparam logic [9:0] GRID_MASK = ~10'((1 << GRID_LOG2) - 1);
  localparam logic [9:0] XMIN_C    = 10'(X_MIN);
  localparam logic [9:0] XMAX_C    = 10'(X_MAX);
  localparam logic [9:0] YMIN_C    = 10'(Y_MIN);
  localparam logic [9:0] YMAX_C    = 10'(Y_MAX);
  localparam logic [9:0] DEFX_C    = 10'(DEF_X);
  localparam logic [9:0] DEFY_C    = 10'(DEF_Y);
  localparam logic [3:0] TRIES_C   = 4'(MAX_TRIES);

  typedef enum logic [2:0] {
    IDLE, DRIVE, WAIT, SAMPLE, CHECK, RETRY, PLACED
  } state_t;

  state_t     state;
  logic [3:0] retry_cnt;
  logic [9:0] cx, cy;
  logic       in_bounds;

  // Snap the candidate onto the grid, then test it against the play field.
  assign cx        = rand_x & GRID_MASK;
  assign cy        = rand_y & GRID_MASK;
  assign in_bounds = (cx >= XMIN_C) && (cx <= XMAX_C) &&
                     (cy >= YMIN_C) && (cy <= YMAX_C);

`ifdef CAKE_TIMEOUT_EN
  localparam logic [28:0] LIFE_LAST = 29'(TIMEOUT_CYC - 1);
  logic [28:0] life_cnt;
  logic        life_end;
  assign life_end = (life_cnt == LIFE_LAST);
`endif

  // Placement sequencer; every output is a register updated here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      retry_cnt  <= '0;
      rand_drive <= 1'b0;
      chk_req    <= 1'b0;
      chk_x      <= '0;
      chk_y      <= '0;
      cake_x     <= DEFX_C;
      cake_y     <= DEFY_C;
      cake_valid <= 1'b0;
      fallback   <= 1'b0;
      eat_cnt    <= '0;
`ifdef CAKE_TIMEOUT_EN
      life_cnt   <= '0;
`endif
    end else begin
      rand_drive <= 1'b0;
      if (game_start) begin
        // Restart wins over everything, including a same-cycle eat or ack.
        state      <= DRIVE;
        rand_drive <= 1'b1;
        cake_valid <= 1'b0;
        chk_req    <= 1'b0;
        eat_cnt    <= '0;
        retry_cnt  <= '0;
      end else begin
        case (state)
          IDLE: ;
          DRIVE: state <= WAIT;
          // Generator captures y on this edge; both coords usable in SAMPLE.
          WAIT: state <= SAMPLE;
          SAMPLE: begin
            if (in_bounds) begin
              chk_x   <= cx;
              chk_y   <= cy;
              chk_req <= 1'b1;
              state   <= CHECK;
            end else begin
              state <= RETRY;
            end
          end
          CHECK: begin
            if (chk_ack) begin
              chk_req <= 1'b0;
              if (chk_hit) begin
                state <= RETRY;
              end else begin
                cake_x     <= chk_x;
                cake_y     <= chk_y;
                fallback   <= 1'b0;
                cake_valid <= 1'b1;
                state      <= PLACED;
`ifdef CAKE_TIMEOUT_EN
                life_cnt   <= '0;
`endif
              end
            end
          end
          RETRY: begin
            retry_cnt <= retry_cnt + 4'd1;
            if (retry_cnt + 4'd1 == TRIES_C) begin
              // Out of tries: use the fixed cell, no body check.
              cake_x     <= DEFX_C;
              cake_y     <= DEFY_C;
              fallback   <= 1'b1;
              cake_valid <= 1'b1;
              state      <= PLACED;
`ifdef CAKE_TIMEOUT_EN
              life_cnt   <= '0;
`endif
            end else begin
              rand_drive <= 1'b1;
              state      <= DRIVE;
            end
          end
          PLACED: begin
            retry_cnt <= '0;
`ifdef CAKE_TIMEOUT_EN
            life_cnt  <= life_cnt + 29'd1;
`endif
            if (eaten) begin
              cake_valid <= 1'b0;
              if (eat_cnt != 8'hFF) eat_cnt <= eat_cnt + 8'd1;
              rand_drive <= 1'b1;
              state      <= DRIVE;
            end
`ifdef CAKE_TIMEOUT_EN
            else if (life_end) begin
              cake_valid <= 1'b0;
              rand_drive <= 1'b1;
              state      <= DRIVE;
            end
`endif
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cake_place_ctrl.sv
// Directed bench for cake_place_ctrl with a behavioural cake generator
// (x loads on the strobe edge, y one edge later) and an occupancy
// responder whose hit answers come from a queue.
module tb_cake_place_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       game_start = 1'b0;
  logic       eaten = 1'b0;
  logic       rand_drive;
  logic [9:0] rand_x = '0;
  logic [9:0] rand_y = '0;
  logic       chk_req;
  logic [9:0] chk_x, chk_y;
  logic       chk_ack = 1'b0;
  logic       chk_hit = 1'b0;
  logic [9:0] cake_x, cake_y;
  logic       cake_valid, fallback;
  logic [7:0] eat_cnt;

  int n_vec = 0;
  int n_err = 0;

  cake_place_ctrl #(.TIMEOUT_CYC(20)) dut (
    .clk(clk), .rst_n(rst_n), .game_start(game_start), .eaten(eaten),
    .rand_drive(rand_drive), .rand_x(rand_x), .rand_y(rand_y),
    .chk_req(chk_req), .chk_x(chk_x), .chk_y(chk_y),
    .chk_ack(chk_ack), .chk_hit(chk_hit),
    .cake_x(cake_x), .cake_y(cake_y), .cake_valid(cake_valid),
    .fallback(fallback), .eat_cnt(eat_cnt)
  );

  always #5 clk = ~clk;

  // Cake generator model.
  logic [9:0] xq[$];
  logic [9:0] yq[$];
  logic [9:0] y_hold = '0;
  logic       y_load = 1'b0;
  int         drive_cnt = 0;
  always @(posedge clk) begin
    y_load <= 1'b0;
    if (rand_drive) begin
      drive_cnt <= drive_cnt + 1;
      rand_x    <= (xq.size() > 0) ? xq.pop_front() : 10'h055;
      y_hold    <= (yq.size() > 0) ? yq.pop_front() : 10'h055;
      y_load    <= 1'b1;
    end
    if (y_load) rand_y <= y_hold;
  end

  // Occupancy responder; late_req forces an unsolicited ack pulse.
  bit   hq[$];
  int   ack_dly = 0;
  bit   ack_en = 1'b1;
  int   wait_c = 0;
  int   req_cnt = 0;
  int   late_req = 0;
  int   late_done = 0;
  logic req_q = 1'b0;
  always @(posedge clk) begin
    chk_ack <= 1'b0;
    chk_hit <= 1'b0;
    req_q   <= chk_req;
    if (chk_req && !req_q) req_cnt <= req_cnt + 1;
    if (late_req != late_done) begin
      late_done <= late_req;
      chk_ack   <= 1'b1;
    end else if (ack_en && chk_req && !chk_ack) begin
      if (wait_c >= ack_dly) begin
        chk_ack <= 1'b1;
        chk_hit <= (hq.size() > 0) ? hq.pop_front() : 1'b0;
        wait_c  <= 0;
      end else begin
        wait_c <= wait_c + 1;
      end
    end else begin
      wait_c <= 0;
    end
  end

  task automatic pulse_start();
    @(negedge clk); game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
  endtask

  task automatic wait_valid(input int bound, output int cyc);
    int c = 0;
    while (!cake_valid && c < bound) begin @(negedge clk); c++; end
    cyc = c;
  endtask

  task automatic wait_req(input int bound, output int cyc);
    int c = 0;
    while (!chk_req && c < bound) begin @(negedge clk); c++; end
    cyc = c;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_vec++; if ({rand_drive, chk_req, cake_valid, fallback} !== 4'b0000) begin n_err++; $display("FAIL reset_flags: got %b want 0000", {rand_drive, chk_req, cake_valid, fallback}); end
    n_vec++; if (eat_cnt !== 8'd0) begin n_err++; $display("FAIL reset_eat_cnt: got %0d want 0", eat_cnt); end
    n_vec++; if (cake_x !== 10'd304 || cake_y !== 10'd304) begin n_err++; $display("FAIL reset_cake: got %h,%h want 130,130", cake_x, cake_y); end
    n_vec++; if (chk_x !== 10'd0 || chk_y !== 10'd0) begin n_err++; $display("FAIL reset_chk: got %h,%h want 0,0", chk_x, chk_y); end
  endtask

  task automatic test_basic();
    int c, d0, r0;
    d0 = drive_cnt; r0 = req_cnt;
    xq.push_back(10'h135); yq.push_back(10'h0A7);
    pulse_start();
    n_vec++; if (rand_drive !== 1'b1) begin n_err++; $display("FAIL basic_drive_on: got %b want 1", rand_drive); end
    @(negedge clk);
    n_vec++; if (rand_drive !== 1'b0) begin n_err++; $display("FAIL basic_drive_off: got %b want 0", rand_drive); end
    wait_valid(40, c);
    n_vec++; if (c !== 4) begin n_err++; $display("FAIL basic_latency: got %0d want 4", c); end
    n_vec++; if (chk_x !== 10'h130 || chk_y !== 10'h0A0) begin n_err++; $display("FAIL basic_chk_xy: got %h,%h want 130,0a0", chk_x, chk_y); end
    n_vec++; if (cake_x !== 10'h130 || cake_y !== 10'h0A0) begin n_err++; $display("FAIL basic_cake_xy: got %h,%h want 130,0a0", cake_x, cake_y); end
    n_vec++; if (fallback !== 1'b0) begin n_err++; $display("FAIL basic_fallback: got %b want 0", fallback); end
    n_vec++; if (drive_cnt - d0 !== 1 || req_cnt - r0 !== 1) begin n_err++; $display("FAIL basic_counts: got drives %0d reqs %0d want 1 1", drive_cnt - d0, req_cnt - r0); end
  endtask

  task automatic test_reject();
    int c, d0, r0;
    d0 = drive_cnt; r0 = req_cnt;
    xq.push_back(10'h005); yq.push_back(10'h050);
    xq.push_back(10'h10C); yq.push_back(10'h06F);
    pulse_start();
    wait_valid(60, c);
    n_vec++; if (!cake_valid) begin n_err++; $display("FAIL reject_timeout: got invalid want valid"); end
    n_vec++; if (drive_cnt - d0 !== 2 || req_cnt - r0 !== 1) begin n_err++; $display("FAIL reject_counts: got drives %0d reqs %0d want 2 1", drive_cnt - d0, req_cnt - r0); end
    n_vec++; if (cake_x !== 10'h100 || cake_y !== 10'h060 || fallback !== 1'b0) begin n_err++; $display("FAIL reject_cake: got %h,%h fb %b want 100,060 fb 0", cake_x, cake_y, fallback); end
  endtask

  task automatic test_bounds();
    int c, d0, r0;
    d0 = drive_cnt; r0 = req_cnt;
    xq.push_back(10'h270); yq.push_back(10'h100);
    xq.push_back(10'h00F); yq.push_back(10'h100);
    xq.push_back(10'h100); yq.push_back(10'h1D0);
    xq.push_back(10'h100); yq.push_back(10'h00F);
    xq.push_back(10'h26F); yq.push_back(10'h1CF);
    pulse_start();
    wait_valid(100, c);
    n_vec++; if (drive_cnt - d0 !== 5 || req_cnt - r0 !== 1) begin n_err++; $display("FAIL bounds_counts: got drives %0d reqs %0d want 5 1", drive_cnt - d0, req_cnt - r0); end
    n_vec++; if (cake_x !== 10'h260 || cake_y !== 10'h1C0 || fallback !== 1'b0) begin n_err++; $display("FAIL bounds_max: got %h,%h fb %b want 260,1c0 fb 0", cake_x, cake_y, fallback); end
    xq.push_back(10'h01F); yq.push_back(10'h010);
    pulse_start();
    wait_valid(40, c);
    n_vec++; if (cake_x !== 10'h010 || cake_y !== 10'h010 || fallback !== 1'b0) begin n_err++; $display("FAIL bounds_min: got %h,%h fb %b want 010,010 fb 0", cake_x, cake_y, fallback); end
  endtask

  task automatic test_fallback();
    int c, d0, r0;
    d0 = drive_cnt; r0 = req_cnt;
    ack_dly = 2;
    for (int i = 0; i < 8; i++) hq.push_back(1'b1);
    pulse_start();
    wait_valid(300, c);
    n_vec++; if (drive_cnt - d0 !== 8 || req_cnt - r0 !== 8) begin n_err++; $display("FAIL fallback_counts: got drives %0d reqs %0d want 8 8", drive_cnt - d0, req_cnt - r0); end
    n_vec++; if (cake_x !== 10'd304 || cake_y !== 10'd304) begin n_err++; $display("FAIL fallback_xy: got %h,%h want 130,130", cake_x, cake_y); end
    n_vec++; if (fallback !== 1'b1 || cake_valid !== 1'b1) begin n_err++; $display("FAIL fallback_flags: got fb %b valid %b want 1 1", fallback, cake_valid); end
    ack_dly = 0;
  endtask

  task automatic test_ignored();
    int c;
    @(negedge clk); late_req++;
    repeat (2) @(negedge clk);
    n_vec++; if (cake_valid !== 1'b1 || chk_req !== 1'b0 || cake_x !== 10'd304) begin n_err++; $display("FAIL stray_ack: got valid %b req %b x %h want 1 0 130", cake_valid, chk_req, cake_x); end
    eaten = 1'b1;
    @(negedge clk);
    @(negedge clk); eaten = 1'b0;
    n_vec++; if (eat_cnt !== 8'd1) begin n_err++; $display("FAIL eat_outside_placed: got %0d want 1", eat_cnt); end
    wait_valid(40, c);
    n_vec++; if (eat_cnt !== 8'd1 || fallback !== 1'b0 || cake_x !== 10'h050) begin n_err++; $display("FAIL eat_replace: got cnt %0d fb %b x %h want 1 0 050", eat_cnt, fallback, cake_x); end
  endtask

  task automatic test_eat_sat();
    int c;
    int exp;
    pulse_start();
    wait_valid(40, c);
    for (int i = 0; i < 256; i++) begin
      @(negedge clk); eaten = 1'b1;
      @(negedge clk); eaten = 1'b0;
      exp = (i + 1 > 255) ? 255 : i + 1;
      n_vec++; if (cake_valid !== 1'b0 || rand_drive !== 1'b1) begin n_err++; $display("FAIL eat_drop[%0d]: got valid %b drive %b want 0 1", i, cake_valid, rand_drive); end
      n_vec++; if (eat_cnt !== 8'(exp)) begin n_err++; $display("FAIL eat_cnt[%0d]: got %0d want %0d", i, eat_cnt, exp); end
      wait_valid(40, c);
      n_vec++; if (cake_valid !== 1'b1) begin n_err++; $display("FAIL eat_replace[%0d]: got invalid want valid", i); end
    end
  endtask

  task automatic test_start_eat();
    int c;
    @(negedge clk); game_start = 1'b1; eaten = 1'b1;
    @(negedge clk); game_start = 1'b0; eaten = 1'b0;
    n_vec++; if (eat_cnt !== 8'd0 || rand_drive !== 1'b1 || cake_valid !== 1'b0) begin n_err++; $display("FAIL start_eat: got cnt %0d drive %b valid %b want 0 1 0", eat_cnt, rand_drive, cake_valid); end
    wait_valid(40, c);
    n_vec++; if (cake_valid !== 1'b1 || eat_cnt !== 8'd0) begin n_err++; $display("FAIL start_eat_place: got valid %b cnt %0d want 1 0", cake_valid, eat_cnt); end
  endtask

  task automatic test_start_mid_query();
    int c;
    logic [9:0] hx;
    ack_en = 1'b0;
    xq.push_back(10'h0C4); yq.push_back(10'h0D8);
    pulse_start();
    wait_req(20, c);
    hx = chk_x;
    repeat (3) @(negedge clk);
    n_vec++; if (chk_req !== 1'b1 || chk_x !== hx || hx !== 10'h0C0) begin n_err++; $display("FAIL req_hold: got req %b x %h want 1 0c0", chk_req, chk_x); end
    game_start = 1'b1;
    @(negedge clk); game_start = 1'b0;
    n_vec++; if (chk_req !== 1'b0 || rand_drive !== 1'b1) begin n_err++; $display("FAIL start_mid_req: got req %b drive %b want 0 1", chk_req, rand_drive); end
    late_req++;
    wait_req(20, c);
    repeat (4) @(negedge clk);
    n_vec++; if (chk_req !== 1'b1 || cake_valid !== 1'b0) begin n_err++; $display("FAIL late_ack: got req %b valid %b want 1 0", chk_req, cake_valid); end
    ack_en = 1'b1;
    wait_valid(40, c);
    n_vec++; if (cake_valid !== 1'b1 || cake_x !== 10'h050) begin n_err++; $display("FAIL mid_query_place: got valid %b x %h want 1 050", cake_valid, cake_x); end
  endtask

  task automatic test_async_reset();
    int c;
    ack_en = 1'b0;
    pulse_start();
    wait_req(20, c);
    #2 rst_n = 1'b0;
    #1;
    n_vec++; if (chk_req !== 1'b0 || cake_valid !== 1'b0) begin n_err++; $display("FAIL async_reset: got req %b valid %b want 0 0", chk_req, cake_valid); end
    @(negedge clk); rst_n = 1'b1; ack_en = 1'b1;
    @(negedge clk);
    n_vec++; if (rand_drive !== 1'b0 || chk_x !== 10'd0 || cake_x !== 10'd304 || eat_cnt !== 8'd0) begin n_err++; $display("FAIL after_reset: got drive %b chk_x %h cake_x %h cnt %0d want 0 000 130 0", rand_drive, chk_x, cake_x, eat_cnt); end
  endtask

`ifdef CAKE_TIMEOUT_EN
  task automatic test_timeout();
    int c;
    logic [7:0] e0;
    pulse_start();
    @(negedge clk); eaten = 1'b1;
    @(negedge clk); eaten = 1'b0;
    wait_valid(40, c);
    e0 = eat_cnt;
    c = 0;
    while (cake_valid && c < 100) begin c++; @(negedge clk); end
    n_vec++; if (c !== 20) begin n_err++; $display("FAIL timeout_life: got %0d want 20", c); end
    n_vec++; if (rand_drive !== 1'b1 || eat_cnt !== e0) begin n_err++; $display("FAIL timeout_redrive: got drive %b cnt %0d want 1 %0d", rand_drive, eat_cnt, e0); end
    wait_valid(40, c);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_reject();
    test_bounds();
    test_fallback();
    test_ignored();
    test_eat_sat();
    test_start_eat();
    test_start_mid_query();
    test_async_reset();
`ifdef CAKE_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
